priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter_pkg.sv | 18 +
 rtl/priority_arbiter_if.sv | 34 +++
 rtl/priority_encoder_core.sv | 33 +++
 rtl/priority_arbiter.sv | 94 +++++++++
 tb/tb_priority_arbiter.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/priority_arbiter_pkg.sv
// Shared types and constants for the priority arbiter.
// Round-robin mode is enabled by defining PRIORITY_ARBITER_RR_EN.
package priority_arbiter_pkg;

    // Largest supported number of request lines.
    localparam int unsigned MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Decrement an index modulo n (0 wraps to n-1).
    function automatic int unsigned wrap_dec(input int unsigned g, input int unsigned n);
        return (g == 0) ? (n - 1) : (g - 1);
    endfunction

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bus between requesters/consumer and the priority arbiter.
// Round-robin mode is enabled by defining PRIORITY_ARBITER_RR_EN.
interface priority_arbiter_if #(
    parameter int N = 8
) ();
    localparam int W = $clog2(N);

    logic [N-1:0] in_lines;
    logic         grant_ack;
    logic         grant_valid;
    logic [W-1:0] out_lines;
    logic [N-1:0] grant_onehot;
    logic         none_active;

    // Requesters and grant consumer.
    modport master (
        output in_lines,
        output grant_ack,
        input  grant_valid,
        input  out_lines,
        input  grant_onehot,
        input  none_active
    );

    // Arbiter side.
    modport slave (
        input  in_lines,
        input  grant_ack,
        output grant_valid,
        output out_lines,
        output grant_onehot,
        output none_active
    );
endinterface

// File: rtl/priority_encoder_core.sv
// Combinational N-to-W MSB-first priority encoder with rotated priority.
// Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; ptr = N-1 gives plain
// highest-index-wins. Used by priority_arbiter (PRIORITY_ARBITER_RR_EN selects
// whether ptr is a register or the constant N-1).
module priority_encoder_core #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk candidates downward from ptr with wraparound; first set line wins.
    always_comb begin
        int unsigned cand;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = int'(ptr) + N - k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                idx = W'(cand);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered two-state (IDLE/GRANT) request arbiter.
// Default build: fixed priority, highest set index wins.
// Define PRIORITY_ARBITER_RR_EN for round-robin: after an acked grant of index
// g the search starts at g-1 (wrapping), and reset restores the pointer to N-1.
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    priority_arbiter_if.slave bus
);

    localparam int W = $clog2(N);

    arb_state_t   state;
    logic         grant_valid_q;
    logic [W-1:0] out_lines_q;
    logic [N-1:0] grant_onehot_q;
    logic         none_active_q;

    logic [W-1:0] ptr;
    logic [W-1:0] win_idx;
    logic         win_any;

`ifdef PRIORITY_ARBITER_RR_EN
    logic [W-1:0] ptr_q;
    assign ptr = ptr_q;
`else
    assign ptr = W'(N - 1);
`endif

    priority_encoder_core #(
        .N (N),
        .W (W)
    ) u_core (
        .req (bus.in_lines),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    // FSM with all outputs registered; a presented grant is held until acked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            grant_valid_q  <= 1'b0;
            out_lines_q    <= '0;
            grant_onehot_q <= '0;
            none_active_q  <= 1'b1;
`ifdef PRIORITY_ARBITER_RR_EN
            ptr_q          <= W'(N - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state          <= GRANT;
                        grant_valid_q  <= 1'b1;
                        out_lines_q    <= win_idx;
                        grant_onehot_q <= N'(1) << win_idx;
                        none_active_q  <= 1'b0;
                    end else begin
                        grant_valid_q  <= 1'b0;
                        out_lines_q    <= '0;
                        grant_onehot_q <= '0;
                        none_active_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (bus.grant_ack) begin
                        state          <= IDLE;
                        grant_valid_q  <= 1'b0;
                        out_lines_q    <= '0;
                        grant_onehot_q <= '0;
`ifdef PRIORITY_ARBITER_RR_EN
                        ptr_q          <= W'(wrap_dec(32'(out_lines_q), N));
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.out_lines    = out_lines_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.none_active  = none_active_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter (N=8).
// Expectations follow PRIORITY_ARBITER_RR_EN when it is defined.
module tb_priority_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    priority_arbiter_if #(.N(8)) bus ();

    priority_arbiter #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic gv, input logic [2:0] ol,
                             input logic [7:0] oh, input logic na);
        check({tag, ".grant_valid"},  32'(bus.grant_valid),  32'(gv));
        check({tag, ".out_lines"},    32'(bus.out_lines),    32'(ol));
        check({tag, ".grant_onehot"}, 32'(bus.grant_onehot), 32'(oh));
        check({tag, ".none_active"},  32'(bus.none_active),  32'(na));
    endtask

    initial begin
        logic [2:0] seq [5];
        logic [2:0] after_abort;
        vectors     = 0;
        miscompares = 0;
`ifdef PRIORITY_ARBITER_RR_EN
        seq         = '{3'd7, 3'd3, 3'd1, 3'd0, 3'd7};
        after_abort = 3'd3;
`else
        seq         = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        after_abort = 3'd7;
`endif

        // Reset
        rst_n         = 1'b0;
        bus.in_lines  = 8'h00;
        bus.grant_ack = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 3'd0, 8'h00, 1'b1);
        rst_n = 1'b1;

        // No requests for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("idle_empty", 1'b0, 3'd0, 8'h00, 1'b1);
        end

        // 0000_0101 -> index 2 one cycle later, held without ack
        bus.in_lines = 8'b0000_0101;
        tick();
        check_all("grant2", 1'b1, 3'd2, 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("hold2", 1'b1, 3'd2, 8'h04, 1'b0);
        end

        // Requester drops: grant is not retracted
        bus.in_lines = 8'h00;
        tick();
        check_all("drop_hold2", 1'b1, 3'd2, 8'h04, 1'b0);
        bus.grant_ack = 1'b1;
        tick();
        check_all("ack2", 1'b0, 3'd0, 8'h00, 1'b0);

        // Ack in IDLE is ignored; none_active comes back
        tick();
        check_all("idle_ack_ignored", 1'b0, 3'd0, 8'h00, 1'b1);
        bus.grant_ack = 1'b0;

        // Reset wins over pending requests, restores pointer
        rst_n        = 1'b0;
        bus.in_lines = 8'b1000_1011;
        tick();
        check_all("reset2", 1'b0, 3'd0, 8'h00, 1'b1);
        rst_n         = 1'b1;
        bus.grant_ack = 1'b1;

        // Held requests, continuous ack: grant / idle alternation
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("seq%0d_grant", i), 1'b1, seq[i], 8'h01 << seq[i], 1'b0);
            tick();
            check_all($sformatf("seq%0d_idle", i), 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // Grant then reset mid-GRANT without ack
        bus.grant_ack = 1'b0;
        tick();
        check_all("pre_abort", 1'b1, after_abort, 8'h01 << after_abort, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all("abort", 1'b0, 3'd0, 8'h00, 1'b1);
        rst_n        = 1'b1;
        bus.in_lines = 8'b1000_1000;
        tick();
        check_all("post_abort", 1'b1, 3'd7, 8'h80, 1'b0);
        bus.grant_ack = 1'b1;
        tick();
        check_all("post_abort_ack", 1'b0, 3'd0, 8'h00, 1'b0);

        // Lowest line alone: index 0 with grant_valid set
        bus.grant_ack = 1'b0;
        bus.in_lines  = 8'h01;
        tick();
        check_all("lowest", 1'b1, 3'd0, 8'h01, 1'b0);
        bus.grant_ack = 1'b1;
        bus.in_lines  = 8'h00;
        tick();
        check_all("lowest_ack", 1'b0, 3'd0, 8'h00, 1'b0);
        bus.grant_ack = 1'b0;
        tick();
        check_all("final_idle", 1'b0, 3'd0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
